// File: rtl/wbm_cmd_initiator.sv
`default_nettype none
// ============================================================================
// Module   : wbm_cmd_initiator
// Brief    : Wishbone classic-cycle initiator. One valid/ready command becomes
//            one WB read/write cycle; the result returns on a response port.
//            Optional bus-hang timeout enabled by defining WBM_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module wbm_cmd_initiator #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int TOUT_CYC = 255
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_n,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic            cmd_we_i,
  input  logic [DW/8-1:0] cmd_sel_i,
  input  logic [AW-1:0]   cmd_adr_i,
  input  logic [DW-1:0]   cmd_dat_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [DW-1:0]   rsp_dat_o,
  output logic            rsp_err_o,
  output logic            rsp_tout_o,
  output logic            wbm_cyc_o,
  output logic            wbm_stb_o,
  output logic            wbm_we_o,
  output logic [DW/8-1:0] wbm_sel_o,
  output logic [AW-1:0]   wbm_adr_o,
  output logic [DW-1:0]   wbm_dat_o,
  input  logic [DW-1:0]   wbm_dat_i,
  input  logic            wbm_ack_i,
  input  logic            wbm_err_i,
  output logic            busy_o
);

  localparam int         c_SW        = DW / 8;
  localparam logic [1:0] c_ST_IDLE   = 2'd0;
  localparam logic [1:0] c_ST_BUS    = 2'd1;
  localparam logic [1:0] c_ST_RESP   = 2'd2;

  logic [1:0]      r_state,     w_state_nxt;
  logic            r_cmd_ready, w_cmd_ready_nxt;
  logic            r_busy,      w_busy_nxt;
  logic            r_cyc,       w_cyc_nxt;
  logic            r_we,        w_we_nxt;
  logic [c_SW-1:0] r_sel,       w_sel_nxt;
  logic [AW-1:0]   r_adr,       w_adr_nxt;
  logic [DW-1:0]   r_dat,       w_dat_nxt;
  logic            r_rsp_valid, w_rsp_valid_nxt;
  logic [DW-1:0]   r_rsp_dat,   w_rsp_dat_nxt;
  logic            r_rsp_err,   w_rsp_err_nxt;

  logic w_accept;
  logic w_tout_hit;
  logic w_tout_abort;
  logic w_bus_done;

`ifdef WBM_TIMEOUT_EN
  localparam int                 c_CNT_W     = ($clog2(TOUT_CYC + 1) > 8) ? $clog2(TOUT_CYC + 1) : 8;
  localparam logic [c_CNT_W-1:0] c_TOUT_LAST = c_CNT_W'(TOUT_CYC - 1);

  logic [c_CNT_W-1:0] r_tcnt, w_tcnt_nxt;
  logic               r_rsp_tout, w_rsp_tout_nxt;

  assign w_tout_hit = (r_tcnt == c_TOUT_LAST);
  assign rsp_tout_o = r_rsp_tout;
`else
  assign w_tout_hit = 1'b0;
  assign rsp_tout_o = 1'b0;
`endif

  assign w_accept     = cmd_valid_i & r_cmd_ready;
  // A slave response on the abort edge takes precedence over the timeout.
  assign w_tout_abort = w_tout_hit & ~wbm_ack_i & ~wbm_err_i;
  assign w_bus_done   = wbm_ack_i | wbm_err_i | w_tout_hit;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin : p_state_reg
    if (!wb_rst_n) begin
      r_state     <= c_ST_IDLE;
      r_cmd_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_cyc       <= 1'b0;
      r_we        <= 1'b0;
      r_sel       <= '0;
      r_adr       <= '0;
      r_dat       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_dat   <= '0;
      r_rsp_err   <= 1'b0;
`ifdef WBM_TIMEOUT_EN
      r_tcnt      <= '0;
      r_rsp_tout  <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_cmd_ready <= w_cmd_ready_nxt;
      r_busy      <= w_busy_nxt;
      r_cyc       <= w_cyc_nxt;
      r_we        <= w_we_nxt;
      r_sel       <= w_sel_nxt;
      r_adr       <= w_adr_nxt;
      r_dat       <= w_dat_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_dat   <= w_rsp_dat_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
`ifdef WBM_TIMEOUT_EN
      r_tcnt      <= w_tcnt_nxt;
      r_rsp_tout  <= w_rsp_tout_nxt;
`endif
    end
  end

  always_comb begin : p_next_state
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: if (w_accept)    w_state_nxt = c_ST_BUS;
      c_ST_BUS:  if (w_bus_done)  w_state_nxt = c_ST_RESP;
      c_ST_RESP: if (rsp_ready_i) w_state_nxt = c_ST_IDLE;
      default:                    w_state_nxt = c_ST_IDLE;
    endcase
  end

  // Computes the next value of every registered output; bus fields simply
  // hold their last value once the cycle ends.
  always_comb begin : p_outputs
    w_cyc_nxt       = r_cyc;
    w_we_nxt        = r_we;
    w_sel_nxt       = r_sel;
    w_adr_nxt       = r_adr;
    w_dat_nxt       = r_dat;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_dat_nxt   = r_rsp_dat;
    w_rsp_err_nxt   = r_rsp_err;
`ifdef WBM_TIMEOUT_EN
    w_tcnt_nxt      = r_tcnt;
    w_rsp_tout_nxt  = r_rsp_tout;
`endif
    case (r_state)
      c_ST_IDLE: begin
        if (w_accept) begin
          w_cyc_nxt  = 1'b1;
          w_we_nxt   = cmd_we_i;
          w_sel_nxt  = cmd_sel_i;
          w_adr_nxt  = cmd_adr_i;
          w_dat_nxt  = cmd_dat_i;
`ifdef WBM_TIMEOUT_EN
          w_tcnt_nxt = '0;
`endif
        end
      end
      c_ST_BUS: begin
        if (w_bus_done) begin
          w_cyc_nxt       = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_err_nxt   = wbm_err_i | w_tout_abort;
          w_rsp_dat_nxt   = (r_we | wbm_err_i | w_tout_abort) ? '0 : wbm_dat_i;
`ifdef WBM_TIMEOUT_EN
          w_rsp_tout_nxt  = w_tout_abort;
        end else begin
          w_tcnt_nxt      = r_tcnt + c_CNT_W'(1);
`endif
        end
      end
      c_ST_RESP: begin
        if (rsp_ready_i) w_rsp_valid_nxt = 1'b0;
      end
      default: begin
        w_cyc_nxt       = 1'b0;
        w_rsp_valid_nxt = 1'b0;
      end
    endcase
    w_cmd_ready_nxt = (w_state_nxt == c_ST_IDLE);
    w_busy_nxt      = (w_state_nxt != c_ST_IDLE);
  end

  assign cmd_ready_o = r_cmd_ready;
  assign busy_o      = r_busy;
  assign wbm_cyc_o   = r_cyc;
  assign wbm_stb_o   = r_cyc;
  assign wbm_we_o    = r_we;
  assign wbm_sel_o   = r_sel;
  assign wbm_adr_o   = r_adr;
  assign wbm_dat_o   = r_dat;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_dat_o   = r_rsp_dat;
  assign rsp_err_o   = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_wbm_cmd_initiator.sv
`default_nettype none
// ============================================================================
// Module   : tb_wbm_cmd_initiator
// Brief    : Self-checking bench for wbm_cmd_initiator (directed + random).
// Revision : 1.0 - initial release
// ============================================================================
module tb_wbm_cmd_initiator;

  localparam int TOUT = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
  logic [3:0]  cmd_sel = '0;
  logic [31:0] cmd_adr = '0, cmd_dat = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_err, rsp_tout;
  logic [31:0] rsp_dat;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat, rdat_in = '0;
  logic        ack = 1'b0, err = 1'b0, busy;

  int total = 0;
  int bad   = 0;
  int cyc_cnt = 0;
  int acc_t   = 0;

  wbm_cmd_initiator #(.AW(32), .DW(32), .TOUT_CYC(TOUT)) dut (
    .wb_clk_i(clk), .wb_rst_n(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_sel_i(cmd_sel), .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat),
    .rsp_err_o(rsp_err), .rsp_tout_o(rsp_tout),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
    .wbm_adr_o(adr), .wbm_dat_o(wdat), .wbm_dat_i(rdat_in),
    .wbm_ack_i(ack), .wbm_err_i(err), .busy_o(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // Expected response as seen by the command issuer: {err, data}.
  function automatic logic [32:0] model_rsp(input logic w, input logic e, input logic [31:0] rd);
    if (e)      return {1'b1, 32'h0};
    else if (w) return {1'b0, 32'h0};
    else        return {1'b0, rd};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one command, wait for acceptance, check the bus was launched.
  task automatic issue(input logic w, input logic [3:0] s, input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 20) begin step(); n++; end
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL issue_wait cmd_ready=%b want=1", cmd_ready); end
    cmd_valid = 1'b1; cmd_we = w; cmd_sel = s; cmd_adr = a; cmd_dat = d;
    step();
    acc_t = cyc_cnt;
    cmd_valid = 1'b0; cmd_we = ~w; cmd_sel = ~s; cmd_adr = $urandom; cmd_dat = $urandom;
    total++;
    if ({cyc, stb, we, sel, adr, wdat, cmd_ready, busy} !== {1'b1, 1'b1, w, s, a, d, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL launch got cyc=%b stb=%b we=%b sel=%h adr=%h dat=%h rdy=%b busy=%b want we=%b sel=%h adr=%h dat=%h",
               cyc, stb, we, sel, adr, wdat, cmd_ready, busy, w, s, a, d);
    end
  endtask

  // Slave answers on the lat-th cycle of cyc; checks cyc length and drop.
  task automatic bus_phase(input int lat, input logic a, input logic e, input logic [31:0] rd);
    int seen = 0;
    for (int k = 1; k <= lat; k++) begin
      if (cyc === 1'b1) seen++;
      if (k == lat) begin ack = a; err = e; rdat_in = rd; end
      step();
      ack = 1'b0; err = 1'b0; rdat_in = $urandom;
    end
    total++;
    if (seen != lat || cyc !== 1'b0 || stb !== 1'b0) begin
      bad++; $display("FAIL cyc_len got=%0d cyc_after=%b want=%0d cyc_after=0", seen, cyc, lat);
    end
  endtask

  // Checks response, holds it for dly cycles, then handshakes.
  task automatic finish_rsp(input logic [32:0] exp, input logic et, input int dly, input logic hold_rdy);
    for (int d = 0; d <= dly; d++) begin
      total++;
      if ({rsp_valid, rsp_err, rsp_dat, rsp_tout, cmd_ready, cyc} !== {1'b1, exp, et, 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL rsp[%0d] got v=%b err=%b dat=%h tout=%b rdy=%b cyc=%b want err=%b dat=%h tout=%b",
                 d, rsp_valid, rsp_err, rsp_dat, rsp_tout, cmd_ready, cyc, exp[32], exp[31:0], et);
      end
      if (d < dly) step();
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = hold_rdy;
    total++;
    if ({rsp_valid, cmd_ready, busy} !== 3'b010) begin
      bad++; $display("FAIL handshake got v=%b rdy=%b busy=%b want 0 1 0", rsp_valid, cmd_ready, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(); step();
    total++;
    if ({cmd_ready, busy, rsp_valid, cyc, stb} !== 5'b10000) begin
      bad++; $display("FAIL reset_ctrl got=%b want=10000", {cmd_ready, busy, rsp_valid, cyc, stb});
    end
    total++;
    if ({rsp_dat, rsp_err, rsp_tout, we, sel, adr, wdat} !== '0) begin
      bad++; $display("FAIL reset_data adr=%h dat=%h rsp=%h want 0", adr, wdat, rsp_dat);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_write();
    issue(1'b1, 4'hF, 32'h3000_0004, 32'hA5A5_5A5A);
    bus_phase(2, 1'b1, 1'b0, 32'hDEAD_BEEF);
    finish_rsp(model_rsp(1'b1, 1'b0, 32'hDEAD_BEEF), 1'b0, 0, 1'b0);
    total++;
    if ({we, sel, adr, wdat} !== {1'b1, 4'hF, 32'h3000_0004, 32'hA5A5_5A5A}) begin
      bad++; $display("FAIL bus_hold got adr=%h dat=%h want adr=30000004 dat=a5a55a5a", adr, wdat);
    end
  endtask

  task automatic test_read();
    issue(1'b0, 4'hF, 32'h3000_0010, 32'h0);
    bus_phase(1, 1'b1, 1'b0, 32'h1234_5678);
    finish_rsp(model_rsp(1'b0, 1'b0, 32'h1234_5678), 1'b0, 2, 1'b0);
  endtask

  task automatic test_err_ack();
    issue(1'b0, 4'h3, 32'h3000_0020, 32'h0);
    bus_phase(1, 1'b1, 1'b1, 32'hCAFE_F00D);
    finish_rsp(model_rsp(1'b0, 1'b1, 32'hCAFE_F00D), 1'b0, 1, 1'b0);
  endtask

  task automatic test_rsp_stall();
    issue(1'b0, 4'hF, 32'h0000_0100, 32'h0);
    bus_phase(1, 1'b1, 1'b0, 32'h0BAD_F00D);
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_sel = 4'h5; cmd_adr = 32'h0000_0200; cmd_dat = 32'h7777_1111;
    finish_rsp(model_rsp(1'b0, 1'b0, 32'h0BAD_F00D), 1'b0, 10, 1'b0);
    total++;
    if (cyc !== 1'b0) begin bad++; $display("FAIL early_accept cyc=%b want=0", cyc); end
    step();
    cmd_valid = 1'b0;
    total++;
    if ({cyc, we, sel, adr, wdat} !== {1'b1, 1'b1, 4'h5, 32'h0000_0200, 32'h7777_1111}) begin
      bad++; $display("FAIL second_cmd got cyc=%b adr=%h dat=%h want cyc=1 adr=00000200 dat=77771111", cyc, adr, wdat);
    end
    bus_phase(1, 1'b1, 1'b0, 32'h0);
    finish_rsp(model_rsp(1'b1, 1'b0, 32'h0), 1'b0, 0, 1'b0);
  endtask

  task automatic test_spurious();
    ack = 1'b1; err = 1'b1; rdat_in = 32'hFFFF_FFFF;
    step(); step();
    ack = 1'b0; err = 1'b0;
    total++;
    if ({cyc, rsp_valid, cmd_ready, busy} !== 4'b0010) begin
      bad++; $display("FAIL spurious got=%b want=0010", {cyc, rsp_valid, cmd_ready, busy});
    end
  endtask

  task automatic test_timeout();
`ifdef WBM_TIMEOUT_EN
    int n = 0;
    issue(1'b0, 4'hF, 32'h4000_0000, 32'h0);
    while (cyc === 1'b1 && n < 40) begin n++; step(); end
    total++;
    if (n != TOUT) begin bad++; $display("FAIL tout_len got=%0d want=%0d", n, TOUT); end
    finish_rsp({1'b1, 32'h0}, 1'b1, 2, 1'b1);
    rsp_ready = 1'b0;
    // Late ack long after the abort must not start anything.
    step(); ack = 1'b1; step(); ack = 1'b0; step();
    total++;
    if ({cyc, rsp_valid, cmd_ready} !== 3'b001) begin
      bad++; $display("FAIL late_ack got=%b want=001", {cyc, rsp_valid, cmd_ready});
    end
    issue(1'b0, 4'hF, 32'h4000_0004, 32'h0);
    bus_phase(TOUT, 1'b1, 1'b0, 32'h5555_AAAA);
    finish_rsp(model_rsp(1'b0, 1'b0, 32'h5555_AAAA), 1'b0, 0, 1'b0);
`else
    issue(1'b0, 4'hF, 32'h4000_0000, 32'h0);
    bus_phase(3 * TOUT, 1'b1, 1'b0, 32'h5555_AAAA);
    finish_rsp(model_rsp(1'b0, 1'b0, 32'h5555_AAAA), 1'b0, 0, 1'b0);
`endif
  endtask

  task automatic test_back_to_back();
    int t0;
    rsp_ready = 1'b1;
    issue(1'b1, 4'h1, 32'h10, 32'h1);
    t0 = acc_t;
    bus_phase(1, 1'b1, 1'b0, 32'h0);
    finish_rsp(model_rsp(1'b1, 1'b0, 32'h0), 1'b0, 0, 1'b1);
    issue(1'b0, 4'h2, 32'h14, 32'h0);
    total++;
    if (acc_t - t0 != 3) begin bad++; $display("FAIL spacing got=%0d want=3", acc_t - t0); end
    bus_phase(1, 1'b1, 1'b0, 32'h9876_5432);
    finish_rsp(model_rsp(1'b0, 1'b0, 32'h9876_5432), 1'b0, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      logic        w  = 1'($urandom);
      logic        e  = ($urandom_range(0, 5) == 0);
      logic        a  = e ? 1'($urandom) : 1'b1;
      logic [3:0]  s  = 4'($urandom);
      logic [31:0] ad = $urandom, d = $urandom, rd = $urandom;
      int          lt = $urandom_range(1, 4);
      int          dl = $urandom_range(0, 3);
      issue(w, s, ad, d);
      if (dl == 0) rsp_ready = 1'b1;
      bus_phase(lt, a, e, rd);
      finish_rsp(model_rsp(w, e, rd), 1'b0, dl, 1'b0);
    end
  endtask

  task automatic test_reset_mid_bus();
    issue(1'b1, 4'hF, 32'h3000_0100, 32'h1111_2222);
    step();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({cyc, stb, cmd_ready, rsp_valid, busy, adr} !== {5'b00100, 32'h0}) begin
      bad++; $display("FAIL async_reset got cyc=%b stb=%b rdy=%b v=%b busy=%b adr=%h want 0 0 1 0 0 0",
                      cyc, stb, cmd_ready, rsp_valid, busy, adr);
    end
    @(posedge clk); #3 rst_n = 1'b1;
    ack = 1'b1; step(); ack = 1'b0; step();
    total++;
    if ({cyc, rsp_valid, cmd_ready} !== 3'b001) begin
      bad++; $display("FAIL post_reset got=%b want=001", {cyc, rsp_valid, cmd_ready});
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_err_ack();
    test_rsp_stall();
    test_spurious();
    test_timeout();
    test_back_to_back();
    test_random();
    test_reset_mid_bus();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
